// File: rtl/fir_mac_pkg.sv
// fir_mac_pkg: shared definitions for the fir_mac_wb FIR engine.
// Holds the Wishbone register word indices, the sequencer state type,
// the accumulator width rule and the output saturation helper.
package fir_mac_pkg;

  localparam logic [3:0] REG_CTRL   = 4'd0;
  localparam logic [3:0] REG_STATUS = 4'd1;
  localparam logic [3:0] REG_LEN    = 4'd2;
  localparam logic [3:0] REG_SHIFT  = 4'd3;
  localparam logic [3:0] REG_CADDR  = 4'd4;
  localparam logic [3:0] REG_CDATA  = 4'd5;
  localparam logic [3:0] REG_XADDR  = 4'd6;
  localparam logic [3:0] REG_XDATA  = 4'd7;
  localparam logic [3:0] REG_YADDR  = 4'd8;
  localparam logic [3:0] REG_YDATA  = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MAC   = 2'd1,
    ST_STORE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Wide enough that NTAPS full-scale products can never wrap.
  function automatic int acc_width(input int dw, input int cw, input int ntaps);
    return dw + cw + $clog2(ntaps);
  endfunction

  // Clamp v to the signed dw-bit range. Result is {sat_flag, value[31:0]},
  // the value sign-extended to 32 bits (dw <= 32).
  function automatic logic [32:0] sat_fn(input logic signed [63:0] v, input int dw);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) begin
      return {1'b1, hi[31:0]};
    end else if (v < lo) begin
      return {1'b1, lo[31:0]};
    end else begin
      return {1'b0, v[31:0]};
    end
  endfunction

endpackage

// File: rtl/fir_mac_dp.sv
// fir_mac_dp: multiply-accumulate datapath of the FIR engine.
// Ports: clk, rst_n (synchronous, active-low), clear (load instead of add),
// enable (accumulate this cycle), c/x (signed operands), shift (arithmetic
// right shift of the accumulator), y (shifted and saturated result),
// sat (y was clamped). y/sat are derived from the accumulator register.
module fir_mac_dp
  import fir_mac_pkg::*;
#(
  parameter int DW    = 16,
  parameter int CW    = 16,
  parameter int NTAPS = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 enable,
  input  logic signed [CW-1:0] c,
  input  logic signed [DW-1:0] x,
  input  logic [5:0]           shift,
  output logic signed [DW-1:0] y,
  output logic                 sat
);

  localparam int ACCW = acc_width(DW, CW, NTAPS);
  localparam int PW   = DW + CW;

  logic signed [PW-1:0]   prod_s;
  logic signed [ACCW-1:0] prod_ext_s;
  logic signed [ACCW-1:0] acc_r;
  logic signed [ACCW-1:0] shifted_s;
  logic signed [31:0]     y_full_s;
  logic                   unused_s;

  assign prod_s     = PW'(c) * PW'(x);
  assign prod_ext_s = ACCW'(prod_s);
  assign shifted_s  = acc_r >>> shift;
  assign {sat, y_full_s} = sat_fn(64'(shifted_s), DW);
  assign y          = y_full_s[DW-1:0];
  assign unused_s   = ^y_full_s;

  // Accumulator: first tap loads the product, later taps add to it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_r <= {ACCW{1'b0}};
    end else if (enable && clear) begin
      acc_r <= prod_ext_s;
    end else if (enable) begin
      acc_r <= acc_r + prod_ext_s;
    end else begin
      acc_r <= acc_r;
    end
  end

endmodule

// File: rtl/fir_mac_wb.sv
// fir_mac_wb: time-multiplexed FIR engine with a Wishbone slave.
// Ports: wb_clk_i clock; wb_rst_i synchronous active-low reset;
// wb_adr_i/wb_dat_i/wb_sel_i/wb_we_i/wb_cyc_i/wb_stb_i slave request;
// wb_dat_o/wb_ack_o/wb_err_o registered response; int_o level interrupt.
// Holds the register file, coefficient/sample/result memories and the
// IDLE/MAC/STORE/DONE sequencer driving fir_mac_dp.
module fir_mac_wb
  import fir_mac_pkg::*;
#(
  parameter int DW    = 16,
  parameter int CW    = 16,
  parameter int NTAPS = 8,
  parameter int DEPTH = 32,
  parameter int AW    = 32
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic [AW-1:0] wb_adr_i,
  input  logic [31:0]   wb_dat_i,
  input  logic [3:0]    wb_sel_i,
  input  logic          wb_we_i,
  input  logic          wb_cyc_i,
  input  logic          wb_stb_i,
  output logic [31:0]   wb_dat_o,
  output logic          wb_ack_o,
  output logic          wb_err_o,
  output logic          int_o
);

  localparam int KW = $clog2(NTAPS);
  localparam int XW = $clog2(DEPTH);
  localparam logic [KW-1:0] K_ZERO  = {KW{1'b0}};
  localparam logic [KW-1:0] K_ONE   = KW'(1);
  localparam logic [KW-1:0] K_LAST  = KW'(NTAPS - 1);
  localparam logic [XW-1:0] X_ZERO  = {XW{1'b0}};
  localparam logic [XW-1:0] X_ONE   = XW'(1);
  localparam logic [XW:0]   N_ZERO  = {(XW + 1){1'b0}};
  localparam logic [XW:0]   N_ONE   = (XW + 1)'(1);
  localparam logic [XW:0]   LEN_MAX = (XW + 1)'(DEPTH);

  logic signed [CW-1:0] c_mem [NTAPS];
  logic signed [DW-1:0] x_mem [DEPTH];
  logic signed [DW-1:0] y_mem [DEPTH];

  state_t        state_r, state_nxt_s;
  logic [KW-1:0] k_r, caddr_r;
  logic [XW:0]   n_r, len_r, len_wr_s, k_ext_s, diff_s;
  logic [XW-1:0] xaddr_r, yaddr_r;
  logic [5:0]    shift_r;
  logic          irq_en_r, done_r, sat_r, start_r, ack_r, err_r;
  logic [31:0]   dat_r, rd_data_s;
  logic [3:0]    idx_s;
  logic          req_s, busy_s, prot_s, reject_s, wr_s;
  logic          dp_clr_s, dp_en_s, y_we_s, done_set_s, dp_sat_s;
  logic signed [DW-1:0] x_tap_s, dp_y_s;
  logic          unused_s;

  assign idx_s    = wb_adr_i[5:2];
  // A new request is taken only when no response is showing, so each access
  // occupies two cycles and back-to-back strobes ack every other cycle.
  assign req_s    = wb_cyc_i & wb_stb_i & ~ack_r & ~err_r;
  assign busy_s   = (state_r != ST_IDLE);
  assign prot_s   = (idx_s == REG_CDATA) | (idx_s == REG_XDATA) |
                    (idx_s == REG_LEN)   | (idx_s == REG_SHIFT);
  assign reject_s = req_s & wb_we_i & busy_s & prot_s;
  assign wr_s     = req_s & wb_we_i & ~reject_s;
  assign len_wr_s = ((wb_dat_i == 32'd0) || (wb_dat_i > 32'(DEPTH))) ? LEN_MAX : wb_dat_i[XW:0];
  assign k_ext_s  = (XW + 1)'(k_r);
  assign diff_s   = n_r - k_ext_s;
  assign unused_s = ^{wb_sel_i, wb_adr_i, diff_s[XW]};

  assign wb_ack_o = ack_r;
  assign wb_err_o = err_r;
  assign wb_dat_o = dat_r;
  assign int_o    = done_r & irq_en_r;

  // Sample for tap k: taps reaching before x[0] contribute zero.
  always_comb begin
    x_tap_s = {DW{1'b0}};
    if (n_r >= k_ext_s) begin
      x_tap_s = x_mem[diff_s[XW-1:0]];
    end else begin
      x_tap_s = {DW{1'b0}};
    end
  end

  fir_mac_dp #(.DW(DW), .CW(CW), .NTAPS(NTAPS)) u_dp (
    .clk    (wb_clk_i),
    .rst_n  (wb_rst_i),
    .clear  (dp_clr_s),
    .enable (dp_en_s),
    .c      (c_mem[k_r]),
    .x      (x_tap_s),
    .shift  (shift_r),
    .y      (dp_y_s),
    .sat    (dp_sat_s)
  );

  // Sequencer next state and datapath strobes.
  always_comb begin
    state_nxt_s = state_r;
    dp_clr_s    = 1'b0;
    dp_en_s     = 1'b0;
    y_we_s      = 1'b0;
    done_set_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start_r) state_nxt_s = ST_MAC;
        else         state_nxt_s = ST_IDLE;
      end
      ST_MAC: begin
        dp_en_s  = 1'b1;
        dp_clr_s = (k_r == K_ZERO);
        if (k_r == K_LAST) state_nxt_s = ST_STORE;
        else               state_nxt_s = ST_MAC;
      end
      ST_STORE: begin
        y_we_s = 1'b1;
        if ((n_r + N_ONE) < len_r) state_nxt_s = ST_MAC;
        else                       state_nxt_s = ST_DONE;
      end
      ST_DONE: begin
        done_set_s  = 1'b1;
        state_nxt_s = ST_IDLE;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Sequencer state plus tap (k) and sample (n) counters.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      state_r <= ST_IDLE;
      k_r     <= K_ZERO;
      n_r     <= N_ZERO;
    end else begin
      state_r <= state_nxt_s;
      case (state_r)
        ST_IDLE: begin
          k_r <= K_ZERO;
          n_r <= N_ZERO;
        end
        ST_MAC:   k_r <= (k_r == K_LAST) ? K_ZERO : k_r + K_ONE;
        ST_STORE: n_r <= n_r + N_ONE;
        default: begin
          k_r <= k_r;
          n_r <= n_r;
        end
      endcase
    end
  end

  // Read data mux; sampled into the response register on request.
  always_comb begin
    rd_data_s = 32'd0;
    case (idx_s)
      REG_CTRL:   rd_data_s = {30'd0, irq_en_r, 1'b0};
      REG_STATUS: rd_data_s = {29'd0, sat_r, done_r, busy_s};
      REG_LEN:    rd_data_s = 32'(len_r);
      REG_SHIFT:  rd_data_s = {26'd0, shift_r};
      REG_CADDR:  rd_data_s = 32'(caddr_r);
      REG_XADDR:  rd_data_s = 32'(xaddr_r);
      REG_YADDR:  rd_data_s = 32'(yaddr_r);
      REG_YDATA:  rd_data_s = 32'(y_mem[yaddr_r]);
      default:    rd_data_s = 32'd0;
    endcase
  end

  // Bus response, control/status registers and pointers.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      ack_r    <= 1'b0;
      err_r    <= 1'b0;
      dat_r    <= 32'd0;
      start_r  <= 1'b0;
      irq_en_r <= 1'b0;
      done_r   <= 1'b0;
      sat_r    <= 1'b0;
      len_r    <= LEN_MAX;
      shift_r  <= 6'd0;
      caddr_r  <= K_ZERO;
      xaddr_r  <= X_ZERO;
      yaddr_r  <= X_ZERO;
    end else begin
      ack_r   <= req_s & ~reject_s;
      err_r   <= reject_s;
      dat_r   <= req_s ? rd_data_s : dat_r;
      start_r <= 1'b0;
      if (done_set_s) done_r <= 1'b1;
      if (y_we_s && dp_sat_s) sat_r <= 1'b1;
      if (wr_s) begin
        case (idx_s)
          REG_CTRL: begin
            irq_en_r <= wb_dat_i[1];
            // START is a pulse; a START during a run is acked but dropped.
            if (wb_dat_i[0] && !busy_s) begin
              start_r <= 1'b1;
              done_r  <= 1'b0;
              sat_r   <= 1'b0;
            end
          end
          REG_LEN:   len_r   <= len_wr_s;
          REG_SHIFT: shift_r <= wb_dat_i[5:0];
          REG_CADDR: caddr_r <= wb_dat_i[KW-1:0];
          REG_CDATA: caddr_r <= (caddr_r == K_LAST) ? K_ZERO : caddr_r + K_ONE;
          REG_XADDR: xaddr_r <= wb_dat_i[XW-1:0];
          REG_XDATA: xaddr_r <= xaddr_r + X_ONE;
          REG_YADDR: yaddr_r <= wb_dat_i[XW-1:0];
          default: begin
          end
        endcase
      end
    end
  end

  // Memories are never cleared by reset.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i && wr_s && (idx_s == REG_CDATA)) c_mem[caddr_r] <= wb_dat_i[CW-1:0];
    if (wb_rst_i && wr_s && (idx_s == REG_XDATA)) x_mem[xaddr_r] <= wb_dat_i[DW-1:0];
    if (wb_rst_i && y_we_s) y_mem[n_r[XW-1:0]] <= dp_y_s;
  end

endmodule

// File: tb/tb_fir_mac_wb.sv
// tb_fir_mac_wb: directed self-checking bench for fir_mac_wb.
// Keeps a behavioural FIR model (plain integer sums over the written
// coefficient/sample arrays) and checks every bus response against it.
module tb_fir_mac_wb;

  localparam int DW = 16, CW = 16, NTAPS = 8, DEPTH = 32, AW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] adr;
  logic [31:0]   dat_w;
  logic [3:0]    sel;
  logic          we, cyc, stb;
  logic [31:0]   dat_r;
  logic          ack, err, irq;

  int n_pass = 0;
  int n_chk  = 0;
  int cycle  = 0;

  int cm [NTAPS];
  int xm [DEPTH];
  int ym [DEPTH];
  bit msat;
  int cptr = 0;
  int xptr = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  fir_mac_wb #(.DW(DW), .CW(CW), .NTAPS(NTAPS), .DEPTH(DEPTH), .AW(AW)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst_n),
    .wb_adr_i (adr),
    .wb_dat_i (dat_w),
    .wb_sel_i (sel),
    .wb_we_i  (we),
    .wb_cyc_i (cyc),
    .wb_stb_i (stb),
    .wb_dat_o (dat_r),
    .wb_ack_o (ack),
    .wb_err_o (err),
    .int_o    (irq)
  );

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, got, exp);
  endtask

  // Reference filter: direct sum, floor shift, clamp to DW bits.
  function automatic void model_run(input int len, input int sh);
    longint acc;
    msat = 1'b0;
    for (int n = 0; n < len; n++) begin
      acc = 0;
      for (int k = 0; k < NTAPS; k++)
        if (n - k >= 0) acc += longint'(cm[k]) * longint'(xm[n - k]);
      acc = acc >>> sh;
      if (acc > 32767) begin acc = 32767; msat = 1'b1; end
      else if (acc < -32768) begin acc = -32768; msat = 1'b1; end
      ym[n] = int'(acc);
    end
  endfunction

  // One Wishbone access; checks the response kind (ack vs err).
  task automatic bus(input logic w, input int idx, input logic [31:0] wd,
                     input logic exp_err, output logic [31:0] rd);
    logic got;
    @(posedge clk); #1;
    adr = 32'(idx) << 2; dat_w = wd; we = w; cyc = 1'b1; stb = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ack || err) begin got = 1'b1; break; end
    end
    rd = dat_r;
    check($sformatf("bus response idx %0d", idx), 32'(got), 32'd1);
    if (got) check($sformatf("err flag idx %0d", idx), 32'(err), 32'(exp_err));
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wr(input int idx, input logic [31:0] v);
    logic [31:0] d;
    bus(1'b1, idx, v, 1'b0, d);
  endtask

  task automatic wr_err(input int idx, input logic [31:0] v);
    logic [31:0] d;
    bus(1'b1, idx, v, 1'b1, d);
  endtask

  task automatic rd_chk(input string nm, input int idx, input logic [31:0] exp);
    logic [31:0] d;
    bus(1'b0, idx, 32'd0, 1'b0, d);
    check(nm, d, exp);
  endtask

  task automatic wr_c(input logic [31:0] v);
    logic signed [CW-1:0] t;
    wr(5, v);
    t = v[CW-1:0];
    cm[cptr] = int'(t);
    cptr = (cptr + 1) % NTAPS;
  endtask

  task automatic wr_x(input logic [31:0] v);
    logic signed [DW-1:0] t;
    wr(7, v);
    t = v[DW-1:0];
    xm[xptr] = int'(t);
    xptr = (xptr + 1) % DEPTH;
  endtask

  task automatic start_run(output int t0);
    wr(0, 32'd3);
    t0 = cycle;
    check("int_o low in START ack cycle", 32'(irq), 32'd0);
  endtask

  // BUSY rises one cycle after the START ack; DONE (and int_o) must rise
  // exactly len*(NTAPS+1)+1 cycles later.
  task automatic wait_done(input string nm, input int t0, input int len);
    int guard;
    guard = 0;
    while (!irq && guard < 5000) begin @(negedge clk); guard++; end
    check(nm, 32'(cycle - t0 - 1), 32'(len * (NTAPS + 1) + 1));
  endtask

  task automatic check_y(input string nm, input int len);
    for (int n = 0; n < len; n++) begin
      wr(8, 32'(n));
      rd_chk($sformatf("%s y[%0d]", nm, n), 9, 32'(ym[n]));
    end
  endtask

  initial begin
    int t0;
    rst_n = 1'b0; adr = '0; dat_w = '0; sel = 4'hF; we = 1'b0; cyc = 1'b0; stb = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("reset ack", 32'(ack), 32'd0);
    check("reset err", 32'(err), 32'd0);
    check("reset int_o", 32'(irq), 32'd0);
    rd_chk("reset CTRL", 0, 32'd0);
    rd_chk("reset STATUS", 1, 32'd0);
    rd_chk("reset LEN", 2, 32'd32);
    rd_chk("reset SHIFT", 3, 32'd0);
    rd_chk("reset CADDR", 4, 32'd0);
    rd_chk("reset XADDR", 6, 32'd0);
    rd_chk("reset YADDR", 8, 32'd0);

    // Impulse response.
    for (int k = 0; k < NTAPS; k++) wr_c(32'(k + 1));
    rd_chk("CADDR wraps after NTAPS writes", 4, 32'd0);
    for (int n = 0; n < DEPTH; n++) wr_x((n == 0) ? 32'd1 : 32'd0);
    rd_chk("XADDR wraps after DEPTH writes", 6, 32'd0);
    wr(2, 32'd16); wr(3, 32'd0);
    model_run(16, 0);
    check("model impulse y0", 32'(ym[0]), 32'd1);
    check("model impulse y7", 32'(ym[7]), 32'd8);
    check("model impulse y8", 32'(ym[8]), 32'd0);
    start_run(t0);
    wait_done("impulse run length", t0, 16);
    check("impulse int_o", 32'(irq), 32'd1);
    rd_chk("impulse STATUS", 1, 32'd2);
    check_y("impulse", 16);

    // Saturation, then the same data shifted down far enough to fit.
    wr(4, 32'd0); cptr = 0;
    for (int k = 0; k < NTAPS; k++) wr_c(32'h7FFF);
    for (int n = 0; n < DEPTH; n++) wr_x(32'h7FFF);
    model_run(16, 0);
    check("model sat y0", 32'(ym[0]), 32'h7FFF);
    check("model sat flag", 32'(msat), 32'd1);
    start_run(t0);
    wait_done("sat run length", t0, 16);
    rd_chk("sat STATUS", 1, 32'd6);
    check_y("sat", 16);
    wr(3, 32'd20);
    model_run(16, 20);
    check("model shift20 y0", 32'(ym[0]), 32'd1023);
    check("model shift20 y7", 32'(ym[7]), 32'd8191);
    start_run(t0);
    wait_done("shift20 run length", t0, 16);
    rd_chk("shift20 STATUS (SAT cleared)", 1, 32'd2);
    check_y("shift20", 16);

    // Negative coefficient with floor shift.
    wr(4, 32'd0); cptr = 0;
    wr_c(32'hFFFF_FFFD);
    for (int k = 1; k < NTAPS; k++) wr_c(32'd0);
    for (int n = 0; n < DEPTH; n++) wr_x(32'd5);
    wr(3, 32'd1); wr(2, 32'd4);
    model_run(4, 1);
    check("model neg y0", 32'(ym[0]), 32'hFFFF_FFF8);
    start_run(t0);
    wait_done("neg run length", t0, 4);
    wr(8, 32'd0);
    rd_chk("neg YDATA literal", 9, 32'hFFFF_FFF8);
    check_y("neg", 4);

    // LEN clamping.
    wr(2, 32'd40); rd_chk("LEN clamp >DEPTH", 2, 32'd32);
    wr(2, 32'd5);  rd_chk("LEN plain", 2, 32'd5);
    wr(2, 32'd0);  rd_chk("LEN clamp 0", 2, 32'd32);

    // Busy protection.
    wr(4, 32'd0); cptr = 0;
    for (int k = 0; k < NTAPS; k++) wr_c(32'(k + 1));
    for (int n = 0; n < DEPTH; n++) wr_x(32'(n + 1));
    wr(3, 32'd0);
    model_run(32, 0);
    start_run(t0);
    wr_err(7, 32'h1234);
    wr(0, 32'd3);
    wr_err(2, 32'd5);
    rd_chk("LEN unchanged while busy", 2, 32'd32);
    rd_chk("XADDR unchanged while busy", 6, 32'(xptr));
    rd_chk("STATUS busy", 1, 32'd1);
    wait_done("busy run length (single run)", t0, 32);
    repeat (20) @(negedge clk);
    rd_chk("STATUS after single run", 1, 32'd2);
    check("int_o held after run", 32'(irq), 32'd1);
    check_y("busy", 32);

    // Unmapped and read-only indices.
    rd_chk("unmapped read", 12, 32'd0);
    wr(12, 32'hFFFF_FFFF);
    wr(1, 32'd7);
    rd_chk("STATUS write ignored", 1, 32'd2);

    // Sample pointer wrap, verified through a unit-impulse filter.
    wr(6, 32'(DEPTH - 1)); xptr = DEPTH - 1;
    wr_x(32'd7); wr_x(32'd9);
    rd_chk("XADDR after wrap", 6, 32'd1);
    wr(4, 32'd0); cptr = 0;
    wr_c(32'd1);
    for (int k = 1; k < NTAPS; k++) wr_c(32'd0);
    model_run(32, 0);
    start_run(t0);
    wait_done("wrap run length", t0, 32);
    wr(8, 32'(DEPTH - 1)); rd_chk("x[DEPTH-1] written", 9, 32'd7);
    wr(8, 32'd0);          rd_chk("x[0] written", 9, 32'd9);
    check_y("wrap", 32);

    // Reset mid-run, then a clean run with the interrupt.
    start_run(t0);
    repeat (50) @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("int_o after reset", 32'(irq), 32'd0);
    check("ack after reset", 32'(ack), 32'd0);
    xptr = 0; cptr = 0;
    rd_chk("STATUS after reset", 1, 32'd0);
    rd_chk("CTRL after reset", 0, 32'd0);
    rd_chk("LEN after reset", 2, 32'd32);
    rd_chk("XADDR after reset", 6, 32'd0);
    repeat (300) @(negedge clk);
    rd_chk("no DONE after aborted run", 1, 32'd0);
    check("int_o stays low after abort", 32'(irq), 32'd0);
    model_run(32, 0);
    start_run(t0);
    wait_done("post-reset run length", t0, 32);
    check("post-reset int_o", 32'(irq), 32'd1);
    rd_chk("post-reset STATUS", 1, 32'd2);
    check_y("post-reset", 32);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fir_mac_wb.md
# fir_mac_wb

Programmable, time-multiplexed FIR filter engine with a Wishbone slave register interface for the DSP core set. Software loads NTAPS signed coefficients and up to DEPTH signed input samples, starts a run, polls or takes an interrupt, then reads back filtered, scaled and saturated outputs. Successor to the fixed-tap streaming FIR wrapper, with:

- parametrised width, tap count and buffer depth
- run-time coefficients, length and output shift
- a real Wishbone handshake, error reporting and interrupt

## Interface
Parameters:
- DW, 16, sample/output width (signed)
- CW, 16, coefficient width (signed)
- NTAPS, 8, tap count (≥2)
- DEPTH, 32, sample/result buffer depth (power of 2)
- AW, 32, Wishbone address width

Ports:
- Clock and reset: one clock; reset is synchronous and active-low.
- wb_clk_i  in  1  clock
- wb_rst_i  in  1  synchronous active-low reset
- wb_adr_i  in  AW  byte address; word index = wb_adr_i[5:2]
- wb_dat_i  in  32  write data
- wb_sel_i  in  4  byte selects (ignored; full-word access only)
- wb_we_i  in  1  write enable
- wb_cyc_i, wb_stb_i  in  1  bus cycle / strobe
- wb_dat_o  out  32  read data, sign-extended where narrower
- wb_ack_o  out  1  access accepted
- wb_err_o  out  1  access rejected
- int_o  out  1  interrupt, level

## Operation
Register map by word index:

- 0 CTRL (RW)
  - bit0 START: write-1 pulse, reads 0
  - bit1 IRQ_EN
- 1 STATUS (RO)
  - bit0 BUSY
  - bit1 DONE: sticky, cleared by START
  - bit2 SAT: sticky, cleared by START
- 2 LEN (RW): sample count N
  - reset DEPTH
  - writes of 0 or >DEPTH clamp to DEPTH
- 3 SHIFT (RW): [5:0] arithmetic right shift applied to the accumulator; reset 0
- 4 CADDR (RW): coefficient pointer; width clog2(NTAPS)
- 5 CDATA (W): stores c[CADDR]; CADDR then increments, wrapping at NTAPS
- 6 XADDR (RW): sample pointer; width clog2(DEPTH)
- 7 XDATA (W): stores x[XADDR]; XADDR then increments, wrapping at DEPTH
- 8 YADDR (RW): result pointer
- 9 YDATA (R): returns y[YADDR], no auto-increment
- Other indices: read 0, writes ignored, ack normally.

Computation:
- y[n] = sat_DW( (Σ_{k=0..NTAPS-1} c[k]·x[n−k]) >>> SHIFT ), for n = 0..N−1.
- x[n−k] = 0 when n−k < 0; there is no history from earlier runs.
- Accumulator width: DW+CW+clog2(NTAPS), signed, never wraps.
- Saturation clamps to [−2^(DW−1), 2^(DW−1)−1] and sets SAT.

FSM:
- IDLE → MAC on START.
- MAC: NTAPS cycles, one product per cycle, tap k = 0..NTAPS−1, accumulator cleared at k=0.
- MAC → STORE: write y[n]; n++.
- STORE → MAC if n < N, else DONE.
- DONE (one cycle) sets DONE, → IDLE.
- START while BUSY is ignored (acked).
- Writes to CDATA, XDATA, LEN or SHIFT while BUSY: no state change, wb_err_o instead of ack.
- Reads are always legal while BUSY. YDATA reads mid-run return the current buffer contents.
- int_o = DONE & IRQ_EN.

## Timing
- Handshake: ack/err registered, asserted the cycle after cyc&stb, deasserted the following cycle (one cycle per access). Back-to-back strobes produce ack every other cycle.
- Write side effects take place in the ack cycle. wb_dat_o is valid in the ack cycle.
- BUSY rises the cycle after the START ack. A run takes exactly N·(NTAPS+1)+1 cycles from BUSY rising to DONE rising, and BUSY falls in the same cycle DONE rises.
- Reset (wb_rst_i=0 at a clock edge):
  - FSM to IDLE.
  - STATUS = 0, CTRL = 0, pointers = 0, LEN = DEPTH, SHIFT = 0.
  - wb_ack_o = wb_err_o = int_o = 0.
  - Coefficient/sample/result memories are not cleared.
  - Reset mid-run aborts immediately, with no DONE.

## Structure
- Package fir_mac_pkg holds:
  - register index localparams
  - FSM state enum (IDLE, MAC, STORE, DONE)
  - accumulator width function
  - saturation helper
- Sub-module fir_mac_dp: signed multiplier, accumulator, shifter and saturator.
  - Inputs: clear, enable, c, x, shift.
  - Outputs: y, sat.
- The top level holds the Wishbone slave, the memories, pointers and the FSM.

## Test plan
- Impulse:
  - Stimulus: NTAPS=8, c = 1..8, x[0]=1, rest 0, N=16, SHIFT=0, START.
  - Response: y[0..7] = 1..8, y[8..15] = 0; DONE after exactly 16·9+1 cycles.
- Saturation:
  - Stimulus: all c = 0x7FFF, all x = 0x7FFF, SHIFT=0.
  - Response: every y[n] = 0x7FFF, SAT=1. Repeat with SHIFT=20 → no saturation, SAT cleared.
- Negative and shift:
  - Stimulus: c[0] = −3, others 0, x = 5, SHIFT=1.
  - Response: y = −8, i.e. floor(−15/2), reads 0xFFFFFFF8.
- Busy protection:
  - Stimulus: write XDATA and a second START during a run.
  - Response: wb_err_o on XDATA; x unchanged; run completes once; XADDR unchanged.
- Pointer wrap:
  - Stimulus: write XADDR=DEPTH−1, then two XDATA writes.
  - Response: XADDR = 1; x[DEPTH−1] and x[0] updated.
- Reset mid-run and interrupt:
  - Stimulus: IRQ_EN=1, START, drop wb_rst_i for one cycle mid-run.
  - Response: BUSY=0, DONE=0, int_o=0, LEN=DEPTH. A new run then raises int_o with DONE.
